// File: rtl/hazard_pkg.sv
// ============================================================================
// Module  : hazard_pkg
// Brief   : Shared constants, select encodings and stage record for hazard_unit
// Revision: 1.0
// ============================================================================
`default_nettype none

package hazard_pkg;

    localparam logic [1:0] C_TNEW_LOAD = 2'd2;
    localparam logic [1:0] C_TNEW_ALU  = 2'd1;
    localparam logic [1:0] C_TNEW_LINK = 2'd0;

    localparam logic [1:0] C_TUSE_0 = 2'd0;
    localparam logic [1:0] C_TUSE_1 = 2'd1;
    localparam logic [1:0] C_TUSE_2 = 2'd2;

    localparam logic [1:0] C_FWD_RF = 2'd0;
    localparam logic [1:0] C_FWD_E  = 2'd1;
    localparam logic [1:0] C_FWD_M  = 2'd2;
    localparam logic [1:0] C_FWD_W  = 2'd3;

    localparam logic C_FWD_ST_CARRY = 1'b0;
    localparam logic C_FWD_ST_W     = 1'b1;

    localparam logic [4:0] C_REG_ZERO = 5'd0;
    localparam logic [4:0] C_REG_RA   = 5'd31;

    typedef struct packed {
        logic [4:0] dest;
        logic [1:0] tnew;
        logic [4:0] rs;
        logic [4:0] rt;
    } stage_info_t;

    typedef struct packed {
        logic       used;
        logic [1:0] tuse;
    } src_use_t;

    function automatic logic src_stalls(input logic [4:0] src, input src_use_t su,
                                        input stage_info_t stg);
        return su.used && (src != C_REG_ZERO) && (stg.dest == src) && (stg.tnew > su.tuse);
    endfunction

    // The youngest matching producer owns the select; if it is not ready yet the
    // select falls back to the carried value and the stall logic covers it.
    function automatic logic [1:0] fwd_select(input logic [4:0] src, input logic allow_e,
                                              input stage_info_t e, input stage_info_t m,
                                              input logic [4:0] w_dest);
        logic [1:0] sel;
        sel = C_FWD_RF;
        if (src == C_REG_ZERO)
            sel = C_FWD_RF;
        else if (allow_e && (e.dest == src))
            sel = (e.tnew == 2'd0) ? C_FWD_E : C_FWD_RF;
        else if (m.dest == src)
            sel = (m.tnew == 2'd0) ? C_FWD_M : C_FWD_RF;
        else if (w_dest == src)
            sel = C_FWD_W;
        return sel;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_stage_reg.sv
// ============================================================================
// Module  : hazard_stage_reg
// Brief   : One tracked pipeline stage record with optional saturating tnew step
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_stage_reg
    import hazard_pkg::*;
#(
    parameter bit DEC_TNEW = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bubble,
    input  stage_info_t next_i,
    output stage_info_t stage_o
);

    stage_info_t r_stage_q;
    stage_info_t w_stage_d;

    always_comb begin
        w_stage_d = next_i;
        if (DEC_TNEW && (next_i.tnew != 2'd0))
            w_stage_d.tnew = next_i.tnew - 2'd1;
        if (bubble)
            w_stage_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_stage_q <= '0;
        else
            r_stage_q <= w_stage_d;
    end

    assign stage_o = r_stage_q;

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
// ============================================================================
// Module  : hazard_unit
// Brief   : Stall and forwarding control for the five-stage MIPS pipeline
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_unit
    import hazard_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       d_cali,
    input  logic       d_calr,
    input  logic       d_br,
    input  logic       d_load,
    input  logic       d_store,
    input  logic       d_jal,
    input  logic       d_jr,
    input  logic       d_jalr,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [4:0] d_rd,
    output logic       stall,
    output logic [1:0] fwd_d_rs,
    output logic [1:0] fwd_d_rt,
    output logic [1:0] fwd_e_rs,
    output logic [1:0] fwd_e_rt,
    output logic       fwd_m_rt
);

    stage_info_t w_d_info;
    stage_info_t w_e_stage;
    stage_info_t w_m_stage;
    src_use_t    w_rs_use;
    src_use_t    w_rt_use;
    logic [4:0]  r_w_dest_q;
    logic        w_unused_m_rs;

    always_comb begin
        w_d_info    = '0;
        w_rs_use    = '0;
        w_rt_use    = '0;
        w_d_info.rs = d_rs;
        w_d_info.rt = d_rt;

        if (d_calr || d_jalr)
            w_d_info.dest = d_rd;
        else if (d_cali || d_load)
            w_d_info.dest = d_rt;
        else if (d_jal)
            w_d_info.dest = C_REG_RA;

        if (d_load)
            w_d_info.tnew = C_TNEW_LOAD;
        else if (d_calr || d_cali)
            w_d_info.tnew = C_TNEW_ALU;
        else
            w_d_info.tnew = C_TNEW_LINK;

        if (d_br || d_jr || d_jalr)
            w_rs_use = '{used: 1'b1, tuse: C_TUSE_0};
        else if (d_calr || d_cali || d_load || d_store)
            w_rs_use = '{used: 1'b1, tuse: C_TUSE_1};

        if (d_br)
            w_rt_use = '{used: 1'b1, tuse: C_TUSE_0};
        else if (d_calr)
            w_rt_use = '{used: 1'b1, tuse: C_TUSE_1};
        else if (d_store)
            w_rt_use = '{used: 1'b1, tuse: C_TUSE_2};
    end

    // E keeps the entry tnew; M applies the one-step decrement on the way in.
    hazard_stage_reg #(.DEC_TNEW(1'b0)) u_stage_e (
        .clk     (clk),
        .reset   (reset),
        .bubble  (stall),
        .next_i  (w_d_info),
        .stage_o (w_e_stage)
    );

    hazard_stage_reg #(.DEC_TNEW(1'b1)) u_stage_m (
        .clk     (clk),
        .reset   (reset),
        .bubble  (1'b0),
        .next_i  (w_e_stage),
        .stage_o (w_m_stage)
    );

    always_ff @(posedge clk) begin
        if (reset)
            r_w_dest_q <= C_REG_ZERO;
        else
            r_w_dest_q <= w_m_stage.dest;
    end

    assign w_unused_m_rs = ^w_m_stage.rs;

    assign stall = src_stalls(d_rs, w_rs_use, w_e_stage) || src_stalls(d_rs, w_rs_use, w_m_stage)
                || src_stalls(d_rt, w_rt_use, w_e_stage) || src_stalls(d_rt, w_rt_use, w_m_stage);

    assign fwd_d_rs = fwd_select(d_rs, 1'b1, w_e_stage, w_m_stage, r_w_dest_q);
    assign fwd_d_rt = fwd_select(d_rt, 1'b1, w_e_stage, w_m_stage, r_w_dest_q);
    assign fwd_e_rs = fwd_select(w_e_stage.rs, 1'b0, w_e_stage, w_m_stage, r_w_dest_q);
    assign fwd_e_rt = fwd_select(w_e_stage.rt, 1'b0, w_e_stage, w_m_stage, r_w_dest_q);

    assign fwd_m_rt = ((w_m_stage.rt != C_REG_ZERO) && (r_w_dest_q == w_m_stage.rt))
                      ? C_FWD_ST_W : C_FWD_ST_CARRY;

endmodule

`default_nettype wire

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage MIPS core. It consumes the per-instruction class signals the D-stage decoder produces: cali, calr, br, load, store, jal, jr and jalr, plus the rs/rt/rd fields. It tracks destination register and remaining result latency (Tnew) for the instructions in E, M and W, and generates the stall/flush and forwarding-select signals for the datapath. It sits beside the D/E/M/W pipeline registers and is the only source of stall and forward decisions.

## Interface
- No parameters. Select encodings and Tuse/Tnew constants come from the shared package.
- clk  in  1  core clock. All state updates on the rising edge.
- reset  in  1  synchronous, active-high. Clears all tracked stage state.
- d_cali, d_calr, d_br, d_load, d_store, d_jal, d_jr, d_jalr  in  1 each  class of the instruction in D. At most one is set; none set means nop or j.
- d_rs, d_rt, d_rd  in  5 each  register fields of the D instruction.
- stall  out  1  freeze PC and F/D register; insert a bubble into E.
- fwd_d_rs, fwd_d_rt  out  2 each  D-stage operand source for branch compare and jr/jalr target. 0=RF, 1=E (PC+8), 2=M, 3=W.
- fwd_e_rs, fwd_e_rt  out  2 each  E-stage ALU operand source. 0=register value carried from D, 2=M, 3=W.
- fwd_m_rt  out  1  M-stage store data source. 0=carried value, 1=W.

## Operation
- **D decode (combinational)**
  - Destination: rd for calr or jalr; rt for cali or load; 31 for jal; otherwise 0.
  - Tnew at E entry: load=2; calr/cali=1; jal/jalr=0.
  - Tuse for rs: br/jr/jalr=0; calr/cali/load/store=1; otherwise no use.
  - Tuse for rt: br=0; calr=1; store=2; otherwise no use.
- **Tracked state**
  - E holds dest, tnew, rs and rt.
  - M holds dest, tnew and rt.
  - W holds dest.
  - Destination 0 means "no write".
- **Advance each clock**
  - If reset: all fields go to 0.
  - Else if stall: E is loaded with a bubble (all fields 0).
  - Else: E is loaded from the D decode.
  - M is loaded from E, with tnew = E.tnew−1, saturating at 0.
  - W is loaded from M.dest. W tnew is always 0.
- **Stall**
  - Asserted if, for either used source s of D (s≠0): E.dest==s and E.tnew>Tuse(s), or M.dest==s and M.tnew>Tuse(s).
  - Sources with no use never stall.
- **Forwarding**
  - A stage X qualifies for source s when s≠0, X.dest==s and X.tnew==0.
  - Priority is E > M > W. The youngest matching producer wins, even if it is not ready: an E match with tnew>0 blocks older stages, and stall covers that case.
  - D operands may select E, M or W.
  - E operands may select M or W, matched against E.rs/E.rt.
  - M store data may select W, matched against M.rt.
  - All select outputs are combinational from tracked state plus D inputs.
  - Selects are don't-care while stall=1, but must still be driven to a defined value.

## Timing
- **Reset values:** after any reset cycle, all tracked fields are 0, stall=0 and every select is 0, regardless of D inputs that reference $0. With nonzero D sources, stall=0 and all selects are 0 in the cycle after reset.
- **Latency:** stall and selects respond combinationally to the D inputs in the same cycle. Tracked state updates one edge later.
- **Maximum stall length:** one load-use stall of 2 cycles (load followed by a Tuse-0 consumer). Every other conflict stalls for at most 1 cycle.
- **Simultaneous events:** reset has priority over stall. A stall never blocks M/W advance.
- **Register 0:** never stalls and is never forwarded.

## Structure
- **Package `hazard_pkg`:** Tuse/Tnew constants, the fwd select encodings, and a stage-info struct (dest, tnew, rs, rt).
- **Sub-module `hazard_stage_reg`:** one tracked stage. Inputs are clk, reset, bubble and the next struct; it applies the saturating tnew decrement. Instantiated for E and M; W is a plain 5-bit register.

## Test plan
- **Load-use:** `lw $1,0($0)` then `addu $2,$1,$1` in D.
  - Cycle 1: stall=1.
  - Cycle 2: stall=0.
  - Cycle 3: with addu in E, fwd_e_rs = fwd_e_rt = 3.
- **Branch after ALU:** `addu $3,$4,$5` in E, `beq $3,$0` in D.
  - First cycle: stall=1.
  - Next cycle: fwd_d_rs=2, stall=0.
- **Load then branch:** `lw $3` in E, `beq $3,$3` in D.
  - Two stall cycles.
  - Then fwd_d_rs = fwd_d_rt = 3.
- **Link then return:** `jal` in E, `jr $31` in D.
  - Same cycle: stall=0, fwd_d_rs=1.
- **Load then store:** `lw $6` then `sw $6,0($7)`.
  - No stall.
  - When sw is in M and lw in W: fwd_m_rt=1.
- **$0 and reset**
  - `ori $0,$0,5` followed by `addu $8,$0,$0`: stall=0 and all selects 0.
  - Separately, with `lw $1` in E and a $1 consumer in D, assert reset for one cycle: next cycle stall=0.
